// File: rtl/aib_axi_traffic_gen.sv
// AXI write-then-readback traffic generator: writes one INCR burst of a seed+beat
// pattern, reads it back, and counts data mismatches and response errors.
module aib_axi_traffic_gen #(
    parameter int ADDRWIDTH = 32,
    parameter int IDWIDTH   = 4
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] cfg_addr,
    input  logic [7:0]           cfg_len,
    input  logic [IDWIDTH-1:0]   cfg_id,
    input  logic [31:0]          cfg_seed,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_cnt,
    output logic [IDWIDTH-1:0]   m_axi_awid,
    output logic [ADDRWIDTH-1:0] m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [IDWIDTH-1:0]   m_axi_wid,
    output logic [127:0]         m_axi_wdata,
    output logic [15:0]          m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [IDWIDTH-1:0]   m_axi_bid,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [IDWIDTH-1:0]   m_axi_arid,
    output logic [ADDRWIDTH-1:0] m_axi_araddr,
    output logic [7:0]           m_axi_arlen,
    output logic [2:0]           m_axi_arsize,
    output logic [1:0]           m_axi_arburst,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [IDWIDTH-1:0]   m_axi_rid,
    input  logic [127:0]         m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rlast,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic [7:0]             len_q;
    logic [IDWIDTH-1:0]     id_q;
    logic [31:0]            seed_q;
    logic [7:0]             beat;
    logic [31:0]            lane;
    logic [127:0]           pattern;
    logic                   start_ok, last_beat;
    logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                   b_err, r_err;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign last_beat = (beat == len_q);
    assign lane      = seed_q + {24'd0, beat};
    assign pattern   = {4{lane}};

    // Valids/readies decode from the registered state only, never from the peer's ready/valid.
    assign m_axi_awvalid = (state == S_AW);
    assign m_axi_wvalid  = (state == S_W);
    assign m_axi_bready  = (state == S_B);
    assign m_axi_arvalid = (state == S_AR);
    assign m_axi_rready  = (state == S_R);

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid  && m_axi_wready;
    assign b_hs  = m_axi_bready  && m_axi_bvalid;
    assign ar_hs = m_axi_arvalid && m_axi_arready;
    assign r_hs  = m_axi_rready  && m_axi_rvalid;

    assign b_err = (m_axi_bresp != 2'b00) || (m_axi_bid != id_q);
    assign r_err = (m_axi_rdata != pattern) || (m_axi_rresp != 2'b00) ||
                   (m_axi_rid != id_q) || (m_axi_rlast != last_beat);

    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = 3'b100;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wid     = id_q;
    assign m_axi_wdata   = pattern;
    assign m_axi_wstrb   = 16'hFFFF;
    assign m_axi_wlast   = m_axi_wvalid && last_beat;
    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = 3'b100;
    assign m_axi_arburst = 2'b01;

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == 8'd0);

    always_ff @(posedge clk_wr) begin
        if (rst_wr) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_AW;
            S_AW:           if (aw_hs) state_nxt = S_W;
            S_W:            if (w_hs && last_beat) state_nxt = S_B;
            S_B:            if (b_hs) state_nxt = S_AR;
            S_AR:           if (ar_hs) state_nxt = S_R;
            // An early rlast is only an error; the beat count alone ends the read burst.
            S_R:            if (r_hs && last_beat) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_wr) begin
        if (rst_wr) begin
            beat    <= 8'd0;
            err_cnt <= 8'd0;
        end else begin
            if (start_ok) begin
                beat    <= 8'd0;
                err_cnt <= 8'd0;
            end
            if (aw_hs || ar_hs) beat <= 8'd0;
            if (w_hs && !last_beat) beat <= beat + 8'd1;
            if (b_hs && b_err) err_cnt <= sat_inc(err_cnt);
            if (r_hs) begin
                if (!last_beat) beat <= beat + 8'd1;
                if (r_err) err_cnt <= sat_inc(err_cnt);
            end
        end
    end

    // Burst configuration is data: captured on an accepted start, not reset.
    always_ff @(posedge clk_wr) begin
        if (start_ok) begin
            addr_q <= cfg_addr;
            len_q  <= cfg_len;
            id_q   <= cfg_id;
            seed_q <= cfg_seed;
        end
    end

endmodule

// File: tb/tb_aib_axi_traffic_gen.sv
// Self-checking bench for aib_axi_traffic_gen: a reactive AXI slave drives each burst
// and every outcome is compared with values derived from the burst configuration.
module tb_aib_axi_traffic_gen;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int FW = AW + 8 + IW + 3 + 2;

    logic          clk_wr = 1'b0;
    logic          rst_wr, start;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_len;
    logic [IW-1:0] cfg_id;
    logic [31:0]   cfg_seed;
    logic          busy, done, pass;
    logic [7:0]    err_cnt;
    logic [IW-1:0] m_axi_awid, m_axi_wid, m_axi_bid, m_axi_arid, m_axi_rid;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]    m_axi_awlen, m_axi_arlen;
    logic [2:0]    m_axi_awsize, m_axi_arsize;
    logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [127:0]  m_axi_wdata, m_axi_rdata;
    logic [15:0]   m_axi_wstrb;

    aib_axi_traffic_gen #(.ADDRWIDTH(AW), .IDWIDTH(IW)) dut (
        .clk_wr(clk_wr), .rst_wr(rst_wr), .start(start), .cfg_addr(cfg_addr),
        .cfg_len(cfg_len), .cfg_id(cfg_id), .cfg_seed(cfg_seed), .busy(busy),
        .done(done), .pass(pass), .err_cnt(err_cnt),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wid(m_axi_wid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk_wr = ~clk_wr;

    int tests_run = 0;
    int tests_failed = 0;

    // Per-beat read corruption mask: bit0 rdata, bit1 rresp, bit2 rid, bit3 rlast.
    logic [3:0]    corrupt [256];

    logic [127:0]  obs_wdata [$];
    logic          obs_wlast [$];
    logic [FW-1:0] obs_aw, obs_ar;
    int            stab_err, overlap_err, wfield_bad, aw_n, aw_vcyc, w_vcyc, ar_vcyc;
    bit            timeout, aw_lat_ok, done_lat_ok, aborted;
    logic          fin_done, fin_pass, fin_busy;
    logic [7:0]    fin_err, post_err;
    logic [6:0]    post_rst;

    task automatic idle_inputs();
        start = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bid = '0; m_axi_bresp = 2'b00;
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rid = '0; m_axi_rresp = 2'b00;
        m_axi_rdata = '0;
    endtask

    task automatic clear_corrupt(input logic [3:0] v);
        for (int k = 0; k < 256; k++) corrupt[k] = v;
    endtask

    // Reactive slave for one start: records what the master presented and how it ended.
    task automatic run_burst(input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [IW-1:0] id, input logic [31:0] seed,
                             input int aw_st, input int w_st, input int ar_st, input bit rnd,
                             input logic [1:0] bresp_v, input logic [IW-1:0] bid_v,
                             input int rst_beat, input bit mid_start);
        logic [FW-1:0] aw_now, ar_now, aw_prev, ar_prev;
        logic [128+1+IW+16-1:0] w_now, w_prev;
        logic aw_pend, w_pend, ar_pend, fin_prev, mid_done;
        logic [31:0] lane;
        int rk, cyc, nact;
        obs_wdata.delete(); obs_wlast.delete();
        stab_err = 0; overlap_err = 0; wfield_bad = 0; aw_n = 0;
        aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0;
        timeout = 0; done_lat_ok = 0; aborted = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0; fin_prev = 0; mid_done = 0;
        aw_prev = '0; ar_prev = '0; w_prev = '0; rk = 0; cyc = 0;
        cfg_addr = addr; cfg_len = len; cfg_id = id; cfg_seed = seed; start = 1;
        @(posedge clk_wr); #1;
        start = 0;
        aw_lat_ok = (m_axi_awvalid === 1'b1) && (done === 1'b0) && (busy === 1'b1) &&
                    (err_cnt === 8'd0);
        while (1) begin
            if (fin_prev) begin
                done_lat_ok = (done === 1'b1) && (busy === 1'b0);
                fin_prev = 0;
            end
            if (done === 1'b1) break;
            if (cyc >= 6000) begin timeout = 1; break; end
            idle_inputs();
            cfg_addr = addr; cfg_len = len; cfg_id = id; cfg_seed = seed;
            nact = int'(m_axi_awvalid) + int'(m_axi_wvalid) + int'(m_axi_bready) +
                   int'(m_axi_arvalid) + int'(m_axi_rready);
            if (nact > 1) overlap_err++;
            aw_now = {m_axi_awaddr, m_axi_awlen, m_axi_awid, m_axi_awsize, m_axi_awburst};
            ar_now = {m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize, m_axi_arburst};
            w_now  = {m_axi_wdata, m_axi_wlast, m_axi_wid, m_axi_wstrb};
            if (aw_pend && (m_axi_awvalid !== 1'b1 || aw_now !== aw_prev)) stab_err++;
            if (w_pend  && (m_axi_wvalid  !== 1'b1 || w_now  !== w_prev))  stab_err++;
            if (ar_pend && (m_axi_arvalid !== 1'b1 || ar_now !== ar_prev)) stab_err++;
            if (rst_beat >= 0 && m_axi_wvalid === 1'b1 && obs_wdata.size() == rst_beat) begin
                rst_wr = 1;
                @(posedge clk_wr); #1;
                post_rst = {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready,
                            m_axi_rready, busy, done};
                post_err = err_cnt;
                rst_wr = 0; aborted = 1;
                break;
            end
            if (mid_start && !mid_done && m_axi_wvalid === 1'b1) begin
                start = 1; cfg_addr = ~addr; cfg_len = len - 8'd1; cfg_id = ~id;
                cfg_seed = ~seed; mid_done = 1;
            end
            if (m_axi_awvalid === 1'b1) begin
                aw_vcyc++; obs_aw = aw_now;
                if (aw_st > 0) aw_st--;
                else m_axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (m_axi_awready) aw_n++;
            end
            if (m_axi_wvalid === 1'b1) begin
                w_vcyc++;
                if (m_axi_wid !== id || m_axi_wstrb !== 16'hFFFF) wfield_bad++;
                if (w_st > 0) w_st--;
                else m_axi_wready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (m_axi_wready) begin
                    obs_wdata.push_back(m_axi_wdata);
                    obs_wlast.push_back(m_axi_wlast);
                end
            end
            if (m_axi_bready === 1'b1) begin
                m_axi_bvalid = 1; m_axi_bid = bid_v; m_axi_bresp = bresp_v;
            end
            if (m_axi_arvalid === 1'b1) begin
                ar_vcyc++; obs_ar = ar_now;
                if (ar_st > 0) ar_st--;
                else m_axi_arready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (m_axi_rready === 1'b1 && rk <= int'(len) && (!rnd || $urandom_range(0, 2) != 0)) begin
                lane = seed + 32'(rk);
                m_axi_rvalid = 1;
                m_axi_rdata  = {4{lane}} ^ (corrupt[rk][0] ? 128'h20 : 128'h0);
                m_axi_rresp  = corrupt[rk][1] ? 2'b10 : 2'b00;
                m_axi_rid    = corrupt[rk][2] ? ~id : id;
                m_axi_rlast  = (rk == int'(len)) ^ corrupt[rk][3];
                if (rk == int'(len)) fin_prev = 1;
                rk++;
            end
            aw_pend = m_axi_awvalid && !m_axi_awready; aw_prev = aw_now;
            w_pend  = m_axi_wvalid  && !m_axi_wready;  w_prev  = w_now;
            ar_pend = m_axi_arvalid && !m_axi_arready; ar_prev = ar_now;
            @(posedge clk_wr); #1;
            cyc++;
        end
        fin_done = done; fin_pass = pass; fin_busy = busy; fin_err = err_cnt;
        idle_inputs();
        cfg_addr = addr; cfg_len = len; cfg_id = id; cfg_seed = seed;
    endtask

    task automatic test_reset();
        idle_inputs(); rst_wr = 1;
        cfg_addr = '0; cfg_len = '0; cfg_id = '0; cfg_seed = '0;
        repeat (3) @(posedge clk_wr);
        #1;
        tests_run++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
             m_axi_wlast, busy, done, pass} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready,
                      m_axi_wlast, busy, done, pass});
        end
        tests_run++;
        if (err_cnt !== 8'd0) begin
            tests_failed++; $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
        end
        rst_wr = 0;
        @(posedge clk_wr); #1;
    endtask

    task automatic test_basic();
        logic [FW-1:0] exp_f;
        clear_corrupt(4'h0);
        run_burst(32'h1000, 8'd3, 4'd2, 32'h10, 0, 0, 0, 0, 2'b00, 4'd2, -1, 0);
        exp_f = {32'h1000, 8'd3, 4'd2, 3'b100, 2'b01};
        tests_run++;
        if (!aw_lat_ok) begin tests_failed++; $display("FAIL basic_aw_latency: awvalid/done/err_cnt wrong one cycle after start"); end
        tests_run++;
        if (obs_aw !== exp_f) begin tests_failed++; $display("FAIL basic_aw_fields: got %h required %h", obs_aw, exp_f); end
        tests_run++;
        if (obs_ar !== exp_f) begin tests_failed++; $display("FAIL basic_ar_fields: got %h required %h", obs_ar, exp_f); end
        tests_run++;
        if (obs_wdata.size() != 4) begin tests_failed++; $display("FAIL basic_w_beats: got %0d required 4", obs_wdata.size()); end
        for (int k = 0; k < obs_wdata.size() && k < 4; k++) begin
            tests_run++;
            if (obs_wdata[k] !== {4{32'h10 + 32'(k)}} || obs_wlast[k] !== (k == 3)) begin
                tests_failed++;
                $display("FAIL basic_w_beat%0d: got %h last %b required lanes %h last %b",
                         k, obs_wdata[k], obs_wlast[k], 32'h10 + 32'(k), k == 3);
            end
        end
        tests_run++;
        if (wfield_bad != 0) begin tests_failed++; $display("FAIL basic_wid_wstrb: got %0d bad beats required 0", wfield_bad); end
        tests_run++;
        if ({timeout, fin_done, fin_pass, fin_busy, fin_err} !== {4'b0110, 8'd0}) begin
            tests_failed++;
            $display("FAIL basic_result: got timeout %b done %b pass %b busy %b err %0d required 0 1 1 0 0",
                     timeout, fin_done, fin_pass, fin_busy, fin_err);
        end
        tests_run++;
        if (!done_lat_ok) begin tests_failed++; $display("FAIL basic_done_latency: done not high the cycle after final R handshake"); end
        tests_run++;
        if (overlap_err != 0) begin tests_failed++; $display("FAIL basic_overlap: got %0d required 0", overlap_err); end
    endtask

    task automatic test_stall();
        clear_corrupt(4'h0);
        run_burst(32'h2000, 8'd3, 4'd5, 32'hA5A5_0000, 5, 5, 5, 0, 2'b00, 4'd5, -1, 0);
        tests_run++;
        if (stab_err != 0) begin tests_failed++; $display("FAIL stall_stability: got %0d violations required 0", stab_err); end
        tests_run++;
        if (aw_vcyc != 6 || w_vcyc != 9 || ar_vcyc != 6) begin
            tests_failed++;
            $display("FAIL stall_valid_cycles: got aw %0d w %0d ar %0d required 6 9 6", aw_vcyc, w_vcyc, ar_vcyc);
        end
        tests_run++;
        if ({timeout, fin_done, fin_pass, fin_err} !== {3'b011, 8'd0}) begin
            tests_failed++;
            $display("FAIL stall_result: got timeout %b done %b pass %b err %0d required 0 1 1 0", timeout, fin_done, fin_pass, fin_err);
        end
    endtask

    task automatic test_errors();
        clear_corrupt(4'h0);
        corrupt[0] = 4'b0001;
        run_burst(32'h3000, 8'd0, 4'd7, 32'h1234_5678, 0, 0, 0, 0, 2'b10, 4'd7, -1, 0);
        tests_run++;
        if (obs_wdata.size() != 1 || obs_wlast[0] !== 1'b1) begin
            tests_failed++; $display("FAIL len0_single_beat: got %0d beats required 1 with wlast", obs_wdata.size());
        end
        tests_run++;
        if ({timeout, fin_done, fin_pass, fin_err} !== {3'b010, 8'd2}) begin
            tests_failed++;
            $display("FAIL errors_result: got timeout %b done %b pass %b err %0d required 0 1 0 2", timeout, fin_done, fin_pass, fin_err);
        end
    endtask

    task automatic test_back_to_back();
        clear_corrupt(4'h0);
        run_burst(32'h3100, 8'd2, 4'd1, 32'h55, 0, 0, 0, 0, 2'b00, 4'd1, -1, 0);
        tests_run++;
        if (!aw_lat_ok) begin tests_failed++; $display("FAIL b2b_restart: done/err_cnt not cleared or awvalid late after start from DONE"); end
        tests_run++;
        if ({timeout, fin_done, fin_pass, fin_err} !== {3'b011, 8'd0}) begin
            tests_failed++; $display("FAIL b2b_result: got done %b pass %b err %0d required 1 1 0", fin_done, fin_pass, fin_err);
        end
    endtask

    task automatic test_wrap();
        clear_corrupt(4'h0);
        run_burst(32'h4000, 8'd1, 4'd3, 32'hFFFF_FFFF, 0, 0, 0, 1, 2'b00, 4'd3, -1, 0);
        tests_run++;
        if (obs_wdata.size() != 2 || obs_wdata[0] !== {4{32'hFFFF_FFFF}} || obs_wdata[1] !== 128'h0) begin
            tests_failed++;
            $display("FAIL wrap_wdata: got beats %0d beat1 %h required 2 beats, beat1 0", obs_wdata.size(),
                     obs_wdata.size() > 1 ? obs_wdata[1] : 128'hx);
        end
        tests_run++;
        if ({timeout, fin_pass, fin_err} !== {2'b01, 8'd0}) begin
            tests_failed++; $display("FAIL wrap_result: got pass %b err %0d required 1 0", fin_pass, fin_err);
        end
    endtask

    task automatic test_reset_mid();
        clear_corrupt(4'h0);
        run_burst(32'h5000, 8'd7, 4'd4, 32'h100, 0, 0, 0, 0, 2'b00, 4'd4, 2, 0);
        tests_run++;
        if (!aborted) begin tests_failed++; $display("FAIL midreset_reached: got no W beat 2 required reset during beat 2"); end
        tests_run++;
        if (post_rst !== 7'b0 || post_err !== 8'd0) begin
            tests_failed++; $display("FAIL midreset_outputs: got %b err %0d required 0000000 err 0", post_rst, post_err);
        end
    endtask

    task automatic test_ignore_and_saturate();
        clear_corrupt(4'h1);
        run_burst(32'h6000, 8'd255, 4'd9, 32'hDEAD_0000, 0, 0, 0, 0, 2'b00, 4'd9, -1, 1);
        tests_run++;
        if (aw_n != 1 || obs_ar !== {32'h6000, 8'd255, 4'd9, 3'b100, 2'b01}) begin
            tests_failed++; $display("FAIL busy_start_ignored: got aw handshakes %0d ar %h required 1 and original cfg", aw_n, obs_ar);
        end
        tests_run++;
        if (obs_wdata.size() != 256) begin tests_failed++; $display("FAIL sat_w_beats: got %0d required 256", obs_wdata.size()); end
        tests_run++;
        if ({timeout, fin_done, fin_pass, fin_err} !== {3'b010, 8'hFF}) begin
            tests_failed++; $display("FAIL sat_result: got done %b pass %b err %0d required 1 0 255", fin_done, fin_pass, fin_err);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a; logic [7:0] l; logic [IW-1:0] id, bid; logic [31:0] s; logic [1:0] br;
        int exp_err;
        for (int it = 0; it < 10; it++) begin
            a = $urandom; l = 8'($urandom_range(0, 15)); id = IW'($urandom); s = $urandom;
            br  = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
            bid = ($urandom_range(0, 4) == 0) ? id ^ 4'h1 : id;
            for (int k = 0; k < 256; k++) corrupt[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            exp_err = (br != 2'b00 || bid != id) ? 1 : 0;
            for (int k = 0; k <= int'(l); k++) if (corrupt[k] != 4'h0) exp_err++;
            if (exp_err > 255) exp_err = 255;
            run_burst(a, l, id, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                      1, br, bid, -1, 0);
            tests_run++;
            if (obs_wdata.size() != int'(l) + 1) begin
                tests_failed++; $display("FAIL rand%0d_w_beats: got %0d required %0d", it, obs_wdata.size(), int'(l) + 1);
            end
            for (int k = 0; k < obs_wdata.size() && k <= int'(l); k++) begin
                tests_run++;
                if (obs_wdata[k] !== {4{s + 32'(k)}} || obs_wlast[k] !== (k == int'(l))) begin
                    tests_failed++;
                    $display("FAIL rand%0d_w_beat%0d: got %h last %b required lanes %h last %b",
                             it, k, obs_wdata[k], obs_wlast[k], s + 32'(k), k == int'(l));
                end
            end
            tests_run++;
            if ({timeout, fin_done, fin_pass, fin_err} !== {2'b01, exp_err == 0, 8'(exp_err)}) begin
                tests_failed++;
                $display("FAIL rand%0d_result: got timeout %b done %b pass %b err %0d required 0 1 %b %0d",
                         it, timeout, fin_done, fin_pass, fin_err, exp_err == 0, exp_err);
            end
            tests_run++;
            if (stab_err != 0 || overlap_err != 0 || wfield_bad != 0 || !done_lat_ok) begin
                tests_failed++;
                $display("FAIL rand%0d_protocol: got stab %0d overlap %0d wfield %0d donelat %b required 0 0 0 1",
                         it, stab_err, overlap_err, wfield_bad, done_lat_ok);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_errors();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_ignore_and_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
